// File: rtl/vx_fair_stream_arb.sv
// vx_fair_stream_arb: registered N-to-1 valid/ready stream arbiter.
// A fair-mask arbiter picks one valid input per cycle; the winner's payload and index
// are captured into a main + skid output buffer so that ready_in never depends on
// ready_out combinationally.
// Optional feature macro: VX_FAIR_STREAM_ARB_PERF_EN adds perf_stalls / perf_grants.
module vx_fair_stream_arb #(
    parameter int NUM_INPUTS     = 4,
    parameter int DATAW          = 32,
    parameter int LOG_NUM_INPUTS = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_INPUTS-1:0]           valid_in,
    input  logic [NUM_INPUTS*DATAW-1:0]     data_in,
    output logic [NUM_INPUTS-1:0]           ready_in,
`ifdef VX_FAIR_STREAM_ARB_PERF_EN
    output logic [63:0]                     perf_stalls,
    output logic [NUM_INPUTS*32-1:0]        perf_grants,
`endif
    output logic                            valid_out,
    output logic [DATAW-1:0]                data_out,
    output logic [LOG_NUM_INPUTS-1:0]       sel_out,
    input  logic                            ready_out
);

    logic [NUM_INPUTS-1:0]     grant_mask;
    logic [NUM_INPUTS-1:0]     rem;
    logic [NUM_INPUTS-1:0]     qual;
    logic [NUM_INPUTS-1:0]     grant_onehot;
    logic [LOG_NUM_INPUTS-1:0] grant_idx;
    logic [DATAW-1:0]          grant_data;
    logic                      has_rem;
    logic                      grant_valid;
    logic                      in_fire;
    logic                      out_fire;

    logic                      main_valid_q, main_valid_d;
    logic [DATAW-1:0]          main_data_q, main_data_d;
    logic [LOG_NUM_INPUTS-1:0] main_sel_q, main_sel_d;
    logic                      skid_valid_q, skid_valid_d;
    logic [DATAW-1:0]          skid_data_q, skid_data_d;
    logic [LOG_NUM_INPUTS-1:0] skid_sel_q, skid_sel_d;

    // Requests not yet served this round take priority; once none remain a new round starts.
    assign rem         = valid_in & ~grant_mask;
    assign has_rem     = |rem;
    assign qual        = has_rem ? rem : valid_in;
    assign grant_valid = |valid_in;

    // Lowest set bit of qual: scan downwards so the lowest index is assigned last.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        grant_data   = data_in[DATAW-1:0];
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (qual[i]) begin
                grant_onehot    = '0;
                grant_onehot[i] = 1'b1;
                grant_idx       = LOG_NUM_INPUTS'(i);
                grant_data      = data_in[i*DATAW +: DATAW];
            end
        end
    end

    // Accept only while the skid slot is free; this uses registered state only.
    assign in_fire  = grant_valid & ~skid_valid_q;
    assign ready_in = grant_onehot & {NUM_INPUTS{~skid_valid_q}};
    assign out_fire = main_valid_q & ready_out;

    generate
        if (NUM_INPUTS > 1) begin : g_mask
            logic [NUM_INPUTS-1:0] mask_q, mask_d;

            // Mask accumulates served inputs within a round; holds unless an input is taken.
            always_comb begin
                mask_d = mask_q;
                if (in_fire) begin
                    mask_d = has_rem ? (mask_q | grant_onehot) : grant_onehot;
                end
            end

            // Mask register.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mask_q <= '0;
                end else begin
                    mask_q <= mask_d;
                end
            end

            assign grant_mask = mask_q;
        end else begin : g_no_mask
            assign grant_mask = '0;
        end
    endgenerate

    // Main/skid buffer next state: main refills from skid first to preserve order.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_sel_d   = main_sel_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_sel_d   = skid_sel_q;
        if (!main_valid_q || out_fire) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_sel_d   = skid_sel_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = grant_data;
                main_sel_d   = grant_idx;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = grant_data;
            skid_sel_d   = grant_idx;
        end
    end

    // Valid flags are reset; a reset drops any buffered entries at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Payload and index storage; meaningless while the matching valid is low.
    always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
        main_sel_q  <= main_sel_d;
        skid_data_q <= skid_data_d;
        skid_sel_q  <= skid_sel_d;
    end

    assign valid_out = main_valid_q;
    assign data_out  = main_data_q;
    assign sel_out   = (NUM_INPUTS > 1) ? main_sel_q : '0;

`ifdef VX_FAIR_STREAM_ARB_PERF_EN
    logic [63:0]              perf_stalls_q, perf_stalls_d;
    logic [NUM_INPUTS*32-1:0] perf_grants_q, perf_grants_d;

    // Stall cycles and per-input accepted transfers; counters wrap naturally.
    always_comb begin
        perf_stalls_d = perf_stalls_q;
        perf_grants_d = perf_grants_q;
        if (main_valid_q && !ready_out) begin
            perf_stalls_d = perf_stalls_q + 64'd1;
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (in_fire && grant_onehot[i]) begin
                perf_grants_d[i*32 +: 32] = perf_grants_q[i*32 +: 32] + 32'd1;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stalls_q <= '0;
            perf_grants_q <= '0;
        end else begin
            perf_stalls_q <= perf_stalls_d;
            perf_grants_q <= perf_grants_d;
        end
    end

    assign perf_stalls = perf_stalls_q;
    assign perf_grants = perf_grants_q;
`endif

endmodule

// File: tb/tb_vx_fair_stream_arb.sv
// Directed-vector bench for vx_fair_stream_arb with a queue scoreboard and output monitor.
module tb_vx_fair_stream_arb;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   valid_in = '0;
    logic [N*W-1:0] data_in = '0;
    logic [N-1:0]   ready_in;
    logic           valid_out;
    logic [W-1:0]   data_out;
    logic [1:0]     sel_out;
    logic           ready_out = 1'b0;
`ifdef VX_FAIR_STREAM_ARB_PERF_EN
    logic [63:0]    perf_stalls;
    logic [N*32-1:0] perf_grants;
`endif

    vx_fair_stream_arb #(
        .NUM_INPUTS(N),
        .DATAW(W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .valid_in(valid_in),
        .data_in(data_in),
        .ready_in(ready_in),
`ifdef VX_FAIR_STREAM_ARB_PERF_EN
        .perf_stalls(perf_stalls),
        .perf_grants(perf_grants),
`endif
        .valid_out(valid_out),
        .data_out(data_out),
        .sel_out(sel_out),
        .ready_out(ready_out)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    bit [33:0]  exp_q[$];
    bit         seq_mode = 1'b0;
    int         out_cnt[N];
    int         seq[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int i, input logic [31:0] v);
        data_in[i*W +: W] = v;
    endtask

    task automatic push(input int s, input logic [31:0] d);
        exp_q.push_back({s[1:0], d});
    endtask

    task automatic do_reset();
        valid_in  = '0;
        ready_out = 1'b0;
        reset     = 1'b1;
        exp_q.delete();
        seq_mode  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every accepted output must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got sel %0d data %0h, expected none", sel_out,
                         data_out);
            end else begin
                bit [33:0] e;
                e = exp_q.pop_front();
                chk("out_sel", 64'(sel_out), 64'(e[33:32]));
                chk("out_data", 64'(data_out), 64'(e[31:0]));
                if (seq_mode) begin
                    chk("seq_monotonic", 64'(data_out[3:0]), 64'(out_cnt[sel_out]));
                    out_cnt[sel_out]++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] rdy_tbl [6];
        logic [N-1:0] acc;
        rdy_tbl[0] = 4'b0001; rdy_tbl[1] = 4'b0010; rdy_tbl[2] = 4'b0100;
        rdy_tbl[3] = 4'b1000; rdy_tbl[4] = 4'b0001; rdy_tbl[5] = 4'b0010;

        // Reset, idle inputs.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("idle_valid_out", 64'(valid_out), 64'd0);
            chk("idle_ready_in", 64'(ready_in), 64'd0);
            tick();
        end

        // Round robin over all four inputs at full throughput.
        do_reset();
        for (int i = 0; i < N; i++) set_d(i, 32'hA0 + i);
        valid_in  = 4'b1111;
        ready_out = 1'b1;
        push(0, 32'hA0); push(1, 32'hA1); push(2, 32'hA2);
        push(3, 32'hA3); push(0, 32'hA0); push(1, 32'hA1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rr_ready_in", 64'(ready_in), 64'(rdy_tbl[c]));
            chk("rr_valid_out", 64'(valid_out), (c > 0) ? 64'd1 : 64'd0);
            tick();
        end
        valid_in = '0;
        @(negedge clk);
        chk("rr_last_valid", 64'(valid_out), 64'd1);
        tick();
        @(negedge clk);
        chk("rr_drained", 64'(valid_out), 64'd0);
        chk("rr_queue_empty", 64'(exp_q.size()), 64'd0);

        // Stall fills main then skid; release drains in order 1, 3, 1.
        do_reset();
        set_d(1, 32'h11); set_d(3, 32'h33);
        valid_in = 4'b1010;
        push(1, 32'h11); push(3, 32'h33); push(1, 32'h11);
        @(negedge clk); chk("stall_rdy0", 64'(ready_in), 64'b0010); tick();
        @(negedge clk); chk("stall_rdy1", 64'(ready_in), 64'b1000);
        chk("stall_sel_main", 64'(sel_out), 64'd1); tick();
        @(negedge clk); chk("stall_rdy2", 64'(ready_in), 64'b0000); tick();
        ready_out = 1'b1;
        @(negedge clk); chk("stall_rdy3", 64'(ready_in), 64'b0000); tick();
        @(negedge clk); chk("stall_rdy4", 64'(ready_in), 64'b0010); tick();
        valid_in = '0;
        repeat (3) tick();
        chk("stall_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("stall_drained", 64'(valid_out), 64'd0);

        // Continuous traffic with toggling ready_out; payload = i*16 + seq.
        do_reset();
        seq_mode = 1'b1;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            out_cnt[i] = 0;
        end
        for (int c = 0; c < 24; c++) begin
            for (int i = 0; i < N; i++) set_d(i, 32'(i * 16 + seq[i]));
            valid_in  = 4'b1111;
            ready_out = (c % 2 == 0);
            @(negedge clk);
            acc = valid_in & ready_in;
            for (int i = 0; i < N; i++) if (acc[i]) push(i, 32'(i * 16 + seq[i]));
            tick();
            for (int i = 0; i < N; i++) if (acc[i]) seq[i]++;
        end
        valid_in  = '0;
        ready_out = 1'b1;
        repeat (4) tick();
        chk("traffic_queue_empty", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < N; i++) chk("traffic_count", 64'(out_cnt[i]), 64'(seq[i]));
        chk("traffic_some_accepted", 64'(seq[0] > 2), 64'd1);

        // Asynchronous reset with main and skid full, then fresh arbitration.
        do_reset();
        set_d(1, 32'h11); set_d(3, 32'h33);
        valid_in = 4'b1010;
        tick();
        tick();
        #2;
        chk("areset_pre_valid", 64'(valid_out), 64'd1);
        reset = 1'b1;
        valid_in = '0;
        #1;
        chk("areset_valid_drop", 64'(valid_out), 64'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        set_d(1, 32'h21); set_d(2, 32'h22); set_d(3, 32'h23);
        valid_in  = 4'b1110;
        ready_out = 1'b1;
        push(1, 32'h21);
        @(negedge clk); chk("areset_first_grant", 64'(ready_in), 64'b0010); tick();
        valid_in = '0;
        @(negedge clk); chk("areset_out_valid", 64'(valid_out), 64'd1); tick();
        tick();
        chk("areset_queue_empty", 64'(exp_q.size()), 64'd0);

`ifdef VX_FAIR_STREAM_ARB_PERF_EN
        // Ten stall cycles, then eight transfers split evenly between inputs 0 and 1.
        do_reset();
        set_d(0, 32'hC0); set_d(1, 32'hC1);
        valid_in = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            push(0, 32'hC0);
            push(1, 32'hC1);
        end
        for (int c = 0; c < 18; c++) begin
            ready_out = (c >= 11);
            tick();
        end
        valid_in  = '0;
        ready_out = 1'b1;
        repeat (4) tick();
        chk("perf_stalls", perf_stalls, 64'd10);
        chk("perf_grants0", 64'(perf_grants[31:0]), 64'd4);
        chk("perf_grants1", 64'(perf_grants[63:32]), 64'd4);
        chk("perf_grants2", 64'(perf_grants[95:64]), 64'd0);
        chk("perf_queue_empty", 64'(exp_q.size()), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
